// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
// Scans the 5x5 push-button matrix one row at a time and rebuilds a debounced
// 25-bit button vector, btn[5*row+col]. A one-cycle press event reports the
// lowest-indexed newly pressed button whenever btn gains set bits.
//
// Timing with S = SETTLE_CYCLES:
//   row r is driven for S cycles and its columns are captured on the last
//   dwell edge. The capture of row 4 also evaluates the whole frame, so
//   frame results land every 5*S cycles.

module keypad_matrix_scanner #(
    parameter int unsigned SETTLE_CYCLES  = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  col_n,
    output logic [4:0]  row_n,
    output logic [24:0] btn,
    output logic        frame_done,
    output logic        press,
    output logic [3:0]  press_row,
    output logic [3:0]  press_col
);

    localparam int unsigned DW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    DEB_TARGET = 4'(DEBOUNCE_SCANS);

    typedef enum logic [2:0] {
        ROW0 = 3'd0,
        ROW1 = 3'd1,
        ROW2 = 3'd2,
        ROW3 = 3'd3,
        ROW4 = 3'd4
    } row_t;

    // Two-stage synchronizer for the asynchronous column inputs.
    logic [4:0]    col_meta;
    logic [4:0]    col_sync;

    // Scan state.
    row_t          row;
    row_t          next_row;
    logic [DW-1:0] dwell;
    logic          sample_edge;

    // Rows 0..3 of the frame under construction; row 4 is taken directly
    // from the synchronizer on the evaluating edge.
    logic [19:0]   raw;
    logic [24:0]   prev_raw;
    logic [3:0]    stable;

    // Frame evaluation terms.
    logic [4:0]    col_now;
    logic [24:0]   new_raw;
    logic [3:0]    stable_next;
    logic          update;
    logic [24:0]   rise;
    logic [3:0]    lo_row;
    logic [3:0]    lo_col;

    // Resynchronize the column inputs into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col_n;
            col_sync <= col_meta;
        end
    end

    // Active-high column view and the row sequence.
    always_comb begin
        col_now     = ~col_sync;
        sample_edge = (dwell == DWELL_LAST);
        case (row)
            ROW0:    next_row = ROW1;
            ROW1:    next_row = ROW2;
            ROW2:    next_row = ROW3;
            ROW3:    next_row = ROW4;
            default: next_row = ROW0;
        endcase
    end

    // Dwell on each row, then advance; row_n rotates its single low bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell <= '0;
            row   <= ROW0;
            row_n <= 5'b11110;
        end else if (sample_edge) begin
            dwell <= '0;
            row   <= next_row;
            row_n <= {row_n[3:0], row_n[4]};
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    // Store the sampled columns of rows 0..3 at the end of each dwell.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw <= '0;
        end else if (sample_edge) begin
            case (row)
                ROW0:    raw[4:0]   <= col_now;
                ROW1:    raw[9:5]   <= col_now;
                ROW2:    raw[14:10] <= col_now;
                ROW3:    raw[19:15] <= col_now;
                default: ;
            endcase
        end
    end

    // Debounce decision for the frame completed on this edge, and the
    // lowest set bit of the rising set for the press report.
    always_comb begin
        new_raw = {col_now, raw};
        if (new_raw == prev_raw) begin
            stable_next = (stable >= DEB_TARGET) ? DEB_TARGET : stable + 4'd1;
        end else begin
            stable_next = 4'd1;
        end
        update = (stable_next == DEB_TARGET) && (new_raw != btn);
        rise   = new_raw & ~btn;
        lo_row = '0;
        lo_col = '0;
        // Walk downward so the last hit written is the lowest index.
        for (int unsigned i = 25; i > 0; i--) begin
            if (rise[i-1]) begin
                lo_row = 4'((i - 1) / 5);
                lo_col = 4'((i - 1) % 5);
            end
        end
    end

    // Frame evaluation on the row-4 capture edge: debounce, btn update,
    // frame_done and press pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_raw   <= '0;
            stable     <= '0;
            btn        <= '0;
            frame_done <= 1'b0;
            press      <= 1'b0;
            press_row  <= '0;
            press_col  <= '0;
        end else begin
            frame_done <= 1'b0;
            press      <= 1'b0;
            if (sample_edge && (row == ROW4)) begin
                prev_raw   <= new_raw;
                stable     <= stable_next;
                frame_done <= 1'b1;
                if (update) begin
                    btn <= new_raw;
                    if (|rise) begin
                        press     <= 1'b1;
                        press_row <= lo_row;
                        press_col <= lo_col;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner
// Directed bench: a behavioural key matrix drives col_n from row_n, a vector
// table holds hand-computed expectations at specific cycles of each
// scenario, and a hand-written sequence covers reset in mid-frame.

module tb_keypad_matrix_scanner;

    localparam int unsigned S = 4;
    localparam int unsigned D = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  col_n;
    logic [4:0]  row_n;
    logic [24:0] btn;
    logic        frame_done;
    logic        press;
    logic [3:0]  press_row;
    logic [3:0]  press_col;

    logic [24:0] keys = '0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    int unsigned fd_count = 0;
    int unsigned pr_count = 0;

    typedef struct {
        int unsigned scen;
        int unsigned cyc;
        logic [4:0]  row_n;
        logic [24:0] btn;
        logic        fd;
        logic        press;
        logic [3:0]  prow;
        logic [3:0]  pcol;
    } vec_t;

    vec_t vecs[$];

    keypad_matrix_scanner #(
        .SETTLE_CYCLES  (S),
        .DEBOUNCE_SCANS (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .col_n      (col_n),
        .row_n      (row_n),
        .btn        (btn),
        .frame_done (frame_done),
        .press      (press),
        .press_row  (press_row),
        .press_col  (press_col)
    );

    always #5 clk = ~clk;

    // Physical matrix: a held key pulls its column low while its row is driven.
    always_comb begin
        col_n = '1;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (!row_n[r] && keys[5*r+c]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (frame_done) fd_count++;
        if (press) pr_count++;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        keys = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        cyc      = 0;
        fd_count = 0;
        pr_count = 0;
    endtask

    function automatic logic [24:0] keys_for(input int unsigned scen, input int unsigned c);
        logic [24:0] one = 25'd1;
        case (scen)
            2:       return one << 13;
            3:       return (c < 20 || c >= 40) ? one : '0;
            4:       return (one << 6) | (one << 20);
            5:       return (c < 80) ? (one << 13) : '0;
            default: return '0;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned last_cyc[6];
        int unsigned exp_fd[6];
        int unsigned exp_pr[6];
        int unsigned base;
        logic [24:0] b13;
        b13 = 25'd1 << 13;

        last_cyc = '{0, 60, 85, 105, 65, 145};
        exp_fd   = '{0, 3, 4, 5, 3, 7};
        exp_pr   = '{0, 0, 1, 1, 1, 1};

        // scen, cycle, row_n, btn, frame_done, press, press_row, press_col
        vecs.push_back('{1,  0, 5'b11110, 25'd0, 1'b0, 1'b0, 4'd0, 4'd0});
        vecs.push_back('{1,  3, 5'b11110, 25'd0, 1'b0, 1'b0, 4'd0, 4'd0});
        vecs.push_back('{1,  4, 5'b11101, 25'd0, 1'b0, 1'b0, 4'd0, 4'd0});
        vecs.push_back('{1,  8, 5'b11011, 25'd0, 1'b0, 1'b0, 4'd0, 4'd0});
        vecs.push_back('{1, 12, 5'b10111, 25'd0, 1'b0, 1'b0, 4'd0, 4'd0});
        vecs.push_back('{1, 16, 5'b01111, 25'd0, 1'b0, 1'b0, 4'd0, 4'd0});
        vecs.push_back('{1, 19, 5'b01111, 25'd0, 1'b0, 1'b0, 4'd0, 4'd0});
        vecs.push_back('{1, 20, 5'b11110, 25'd0, 1'b1, 1'b0, 4'd0, 4'd0});
        vecs.push_back('{1, 21, 5'b11110, 25'd0, 1'b0, 1'b0, 4'd0, 4'd0});
        vecs.push_back('{1, 40, 5'b11110, 25'd0, 1'b1, 1'b0, 4'd0, 4'd0});
        vecs.push_back('{1, 60, 5'b11110, 25'd0, 1'b1, 1'b0, 4'd0, 4'd0});
        vecs.push_back('{2, 59, 5'b01111, 25'd0, 1'b0, 1'b0, 4'd0, 4'd0});
        vecs.push_back('{2, 60, 5'b11110, b13,   1'b1, 1'b1, 4'd2, 4'd3});
        vecs.push_back('{2, 61, 5'b11110, b13,   1'b0, 1'b0, 4'd2, 4'd3});
        vecs.push_back('{2, 80, 5'b11110, b13,   1'b1, 1'b0, 4'd2, 4'd3});
        vecs.push_back('{3, 60, 5'b11110, 25'd0, 1'b1, 1'b0, 4'd0, 4'd0});
        vecs.push_back('{3, 99, 5'b01111, 25'd0, 1'b0, 1'b0, 4'd0, 4'd0});
        vecs.push_back('{3,100, 5'b11110, 25'd1, 1'b1, 1'b1, 4'd0, 4'd0});
        vecs.push_back('{4, 59, 5'b01111, 25'd0, 1'b0, 1'b0, 4'd0, 4'd0});
        vecs.push_back('{4, 60, 5'b11110, 25'h0100040, 1'b1, 1'b1, 4'd1, 4'd1});
        vecs.push_back('{4, 61, 5'b11110, 25'h0100040, 1'b0, 1'b0, 4'd1, 4'd1});
        vecs.push_back('{5, 60, 5'b11110, b13,   1'b1, 1'b1, 4'd2, 4'd3});
        vecs.push_back('{5,139, 5'b01111, b13,   1'b0, 1'b0, 4'd2, 4'd3});
        vecs.push_back('{5,140, 5'b11110, 25'd0, 1'b1, 1'b0, 4'd2, 4'd3});

        for (int unsigned sc = 1; sc <= 5; sc++) begin
            do_reset();
            for (int unsigned c = 0; c <= last_cyc[sc]; c++) begin
                keys = keys_for(sc, cyc);
                foreach (vecs[k]) begin
                    if (vecs[k].scen == sc && vecs[k].cyc == cyc) begin
                        check($sformatf("s%0d_row_n", sc), 32'(row_n), 32'(vecs[k].row_n));
                        check($sformatf("s%0d_btn", sc), 32'(btn), 32'(vecs[k].btn));
                        check($sformatf("s%0d_frame_done", sc), 32'(frame_done), 32'(vecs[k].fd));
                        check($sformatf("s%0d_press", sc), 32'(press), 32'(vecs[k].press));
                        check($sformatf("s%0d_press_row", sc), 32'(press_row), 32'(vecs[k].prow));
                        check($sformatf("s%0d_press_col", sc), 32'(press_col), 32'(vecs[k].pcol));
                    end
                end
                if (c < last_cyc[sc]) step();
            end
            check($sformatf("s%0d_frame_done_count", sc), fd_count, exp_fd[sc]);
            check($sformatf("s%0d_press_count", sc), pr_count, exp_pr[sc]);
        end

        // Reset in mid-frame with r2,c3 held since the first reset.
        do_reset();
        keys = b13;
        while (cyc < 30) step();
        rst = 1'b1;
        step();
        check("s6_row_n_after_rst", 32'(row_n), 32'(5'b11110));
        check("s6_btn_after_rst", 32'(btn), 32'd0);
        check("s6_fd_after_rst", 32'(frame_done), 32'd0);
        rst  = 1'b0;
        base = cyc;
        for (int i = 0; i < 40 && !frame_done; i++) step();
        check("s6_first_frame_done_delay", cyc - base, 32'd20);
        for (int i = 0; i < 100 && !btn[13]; i++) step();
        check("s6_btn13_delay", cyc - base, 32'd60);
        check("s6_btn_value", 32'(btn), 32'(b13));
        check("s6_press", 32'(press), 32'd1);
        check("s6_press_row", 32'(press_row), 32'd2);
        check("s6_press_col", 32'(press_col), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
